branch_predict_unit: RTL and testbench

//  Branch resolution plus dynamic direction prediction for the RV32I core. Fetch side reads a
//  PC-indexed table of saturating counters to predict taken/not-taken; execute side evaluates the

---
 rtl/bpu_pkg.sv | 35 +++
 rtl/branch_predict_unit_if.sv | 42 ++++
 rtl/branch_predict_unit_branch_cond.sv | 38 +++
 rtl/branch_predict_unit.sv | 108 ++++++++++
 tb/tb_branch_predict_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bpu_pkg
// Purpose  : Shared types and constants for the branch predict unit.
//            Provides the branch funct3 encoding, the default saturating
//            counter type and the weakly-not-taken reset value.
// Ports    : none (package)
// Config   : BPU_STATS_EN is consumed by branch_predict_unit, not here.
// Revision : 1.0 - initial release
// ============================================================================
package bpu_pkg;

  localparam int BPU_CNT_W = 2;

  typedef logic [BPU_CNT_W-1:0] cnt_t;

  // Weakly-not-taken: largest value whose MSB is still 0.
  localparam cnt_t CNT_RESET = cnt_t'((1 << (BPU_CNT_W - 1)) - 1);

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  // Weakly-not-taken value for an arbitrary counter width.
  function automatic logic [31:0] cnt_reset_val(input int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_unit_if
// Purpose  : Bundle of fetch-lookup and execute-resolve signals between the
//            core pipeline (master) and the branch predict unit (slave).
// Ports    : f_pc, f_pred_taken           fetch-side lookup
//            ex_valid/branch/jump/funct3,
//            ex_pc, ex_pred, eq, lt, ltu   execute-side resolve inputs
//            pc_src, mispredict, illegal_br resolve outputs
// Revision : 1.0 - initial release
// ============================================================================
interface branch_predict_unit_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] f_pc;
  logic            f_pred_taken;
  logic            ex_valid;
  logic            ex_branch;
  logic            ex_jump;
  logic [2:0]      ex_funct3;
  logic [PC_W-1:0] ex_pc;
  logic            ex_pred;
  logic            eq;
  logic            lt;
  logic            ltu;
  logic            pc_src;
  logic            mispredict;
  logic            illegal_br;

  modport master (
    output f_pc, ex_valid, ex_branch, ex_jump, ex_funct3, ex_pc, ex_pred,
           eq, lt, ltu,
    input  f_pred_taken, pc_src, mispredict, illegal_br
  );

  modport slave (
    input  f_pc, ex_valid, ex_branch, ex_jump, ex_funct3, ex_pc, ex_pred,
           eq, lt, ltu,
    output f_pred_taken, pc_src, mispredict, illegal_br
  );
endinterface
`default_nettype wire

// File: rtl/branch_predict_unit_branch_cond.sv
`default_nettype none
// ============================================================================
// Module   : branch_cond
// Purpose  : Pure combinational evaluation of an RV32I branch condition from
//            funct3 and the ALU compare flags.
// Ports    : funct3   in  3  branch funct3
//            eq/lt/ltu in 1  ALU compare flags
//            taken    out 1  condition true (0 for reserved encodings)
//            reserved out 1  funct3 is 010 or 011
// Revision : 1.0 - initial release
// ============================================================================
module branch_cond
  import bpu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       eq,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       reserved
);

  always_comb begin
    taken    = 1'b0;
    reserved = 1'b0;
    case (funct3)
      BEQ:     taken = eq;
      BNE:     taken = ~eq;
      BLT:     taken = lt;
      BGE:     taken = ~lt;
      BLTU:    taken = ltu;
      BGEU:    taken = ~ltu;
      default: reserved = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_unit
// Purpose  : Branch resolution and bimodal direction prediction. Fetch reads
//            a PC-indexed table of saturating counters; execute resolves the
//            branch, drives pc_src, flags mispredicts and trains the table.
// Ports    : clk          in   clock, rising edge
//            reset_n      in   synchronous active-low reset
//            bus          slave modport of branch_predict_unit_if
//            stat_branches    out 32  (BPU_STATS_EN only) training events
//            stat_mispredicts out 32  (BPU_STATS_EN only) mispredict cycles
// Config   : BPU_STATS_EN - adds the two statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_unit
  import bpu_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int PHT_DEPTH = 64,
  parameter int CNT_W     = BPU_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  branch_predict_unit_if.slave bus
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
`endif
);

  localparam int               IDX_W   = $clog2(PHT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_reset_val(CNT_W));

  logic [PC_W-1:0]  f_pc;
  logic [PC_W-1:0]  ex_pc;
  logic [IDX_W-1:0] f_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [CNT_W-1:0] pht [PHT_DEPTH];
  logic [CNT_W-1:0] ex_cnt;
  logic [CNT_W-1:0] ex_cnt_next;
  logic             taken;
  logic             reserved_f3;
  logic             is_cond_branch;
  logic             train;
  logic             unused_pc_bits;

  assign f_pc   = bus.f_pc;
  assign ex_pc  = bus.ex_pc;
  // Instructions are word aligned, so bits [1:0] carry no information.
  assign f_idx  = f_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{f_pc[PC_W-1:IDX_W+2], f_pc[1:0],
                            ex_pc[PC_W-1:IDX_W+2], ex_pc[1:0]};

  branch_cond u_cond (
    .funct3   (bus.ex_funct3),
    .eq       (bus.eq),
    .lt       (bus.lt),
    .ltu      (bus.ltu),
    .taken    (taken),
    .reserved (reserved_f3)
  );

  // A slot flagged as both branch and jump behaves as a jump.
  assign is_cond_branch   = bus.ex_valid & bus.ex_branch & ~bus.ex_jump;
  assign train            = is_cond_branch & ~reserved_f3;

  assign bus.pc_src       = bus.ex_valid & (bus.ex_jump | (bus.ex_branch & taken));
  assign bus.mispredict   = train & (taken != bus.ex_pred);
  assign bus.illegal_br   = bus.ex_valid & bus.ex_branch & reserved_f3;

  // Read is from the registered table, so a same-cycle write is seen next cycle.
  assign bus.f_pred_taken = pht[f_idx][CNT_W-1];

  assign ex_cnt = pht[ex_idx];

  always_comb begin
    ex_cnt_next = ex_cnt;
    if (taken) begin
      if (ex_cnt != '1) ex_cnt_next = ex_cnt + CNT_W'(1);
    end else begin
      if (ex_cnt != '0) ex_cnt_next = ex_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= CNT_RST;
    end else if (train) begin
      pht[ex_idx] <= ex_cnt_next;
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stat_branches    <= 32'd0;
      stat_mispredicts <= 32'd0;
    end else begin
      if (train)          stat_branches    <= stat_branches + 32'd1;
      if (bus.mispredict) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_unit
// Purpose  : Self-checking bench for branch_predict_unit: a condition table
//            followed by directed training, saturation, aliasing, jump,
//            illegal, same-cycle and reset sequences (plus statistics when
//            BPU_STATS_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;
  import bpu_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  branch_predict_unit_if #(.PC_W(32)) bus ();

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predict_unit #(.PC_W(32), .PHT_DEPTH(64), .CNT_W(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .bus              (bus)
`ifdef BPU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string name;
    logic  src, mis, ill, cp, pred;
  } exp_t;

  typedef struct {
    string       name;
    logic        rst_n, valid, branch, jump;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic        pred, eq, lt, ltu;
    logic [31:0] fpc;
    logic        e_src, e_mis, e_ill, cp, e_pred;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[19];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic r, input logic v,
                              input logic b, input logic j, input logic [2:0] f3,
                              input logic [31:0] pc, input logic pred, input logic eq,
                              input logic lt, input logic ltu, input logic [31:0] fpc,
                              input logic src, input logic mis, input logic ill,
                              input logic cp, input logic ep);
    vec_t x;
    x.name = n; x.rst_n = r; x.valid = v; x.branch = b; x.jump = j; x.f3 = f3;
    x.pc = pc; x.pred = pred; x.eq = eq; x.lt = lt; x.ltu = ltu; x.fpc = fpc;
    x.e_src = src; x.e_mis = mis; x.e_ill = ill; x.cp = cp; x.e_pred = ep;
    return x;
  endfunction

  // Drive at the falling edge, expect pushed, compare just before the rising edge.
  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    reset_n       = v.rst_n;
    bus.ex_valid  = v.valid;
    bus.ex_branch = v.branch;
    bus.ex_jump   = v.jump;
    bus.ex_funct3 = v.f3;
    bus.ex_pc     = v.pc;
    bus.ex_pred   = v.pred;
    bus.eq        = v.eq;
    bus.lt        = v.lt;
    bus.ltu       = v.ltu;
    bus.f_pc      = v.fpc;
    sb.push_back('{v.name, v.e_src, v.e_mis, v.e_ill, v.cp, v.e_pred});
    #4;
    e = sb.pop_front();
    chk({e.name, " pc_src"},     {31'd0, bus.pc_src},     {31'd0, e.src});
    chk({e.name, " mispredict"}, {31'd0, bus.mispredict}, {31'd0, e.mis});
    chk({e.name, " illegal_br"}, {31'd0, bus.illegal_br}, {31'd0, e.ill});
    if (e.cp) chk({e.name, " f_pred_taken"}, {31'd0, bus.f_pred_taken}, {31'd0, e.pred});
  endtask

  task automatic brq(input string n, input logic [2:0] f3, input logic [31:0] pc,
                     input logic eq, input logic pred, input logic [31:0] fpc,
                     input logic src, input logic mis, input logic ep);
    apply(mk(n, 1, 1, 1, 0, f3, pc, pred, eq, 0, 0, fpc, src, mis, 0, 1, ep));
  endtask

  task automatic idle(input string n, input logic [31:0] fpc, input logic ep);
    apply(mk(n, 1, 0, 0, 0, 3'b000, 32'h0, 0, 0, 0, 0, fpc, 0, 0, 0, 1, ep));
  endtask

  task automatic rst();
    apply(mk("reset", 0, 0, 0, 0, 3'b000, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    // name, rst_n, valid, branch, jump, f3, pc, pred, eq, lt, ltu, fpc, src, mis, ill, cp, ep
    tbl[0]  = mk("beq_t",   1, 1, 1, 0, BEQ,    32'h3FC, 1, 1, 0, 0, 32'h3FC, 1, 0, 0, 0, 0);
    tbl[1]  = mk("beq_nt",  1, 1, 1, 0, BEQ,    32'h3FC, 1, 0, 0, 0, 32'h3FC, 0, 1, 0, 0, 0);
    tbl[2]  = mk("bne_t",   1, 1, 1, 0, BNE,    32'h3FC, 0, 0, 0, 0, 32'h3FC, 1, 1, 0, 0, 0);
    tbl[3]  = mk("bne_nt",  1, 1, 1, 0, BNE,    32'h3FC, 0, 1, 0, 0, 32'h3FC, 0, 0, 0, 0, 0);
    tbl[4]  = mk("blt_t",   1, 1, 1, 0, BLT,    32'h3FC, 1, 0, 1, 0, 32'h3FC, 1, 0, 0, 0, 0);
    tbl[5]  = mk("blt_nt",  1, 1, 1, 0, BLT,    32'h3FC, 0, 0, 0, 1, 32'h3FC, 0, 0, 0, 0, 0);
    tbl[6]  = mk("bge_t",   1, 1, 1, 0, BGE,    32'h3FC, 0, 0, 0, 0, 32'h3FC, 1, 1, 0, 0, 0);
    tbl[7]  = mk("bge_nt",  1, 1, 1, 0, BGE,    32'h3FC, 1, 0, 1, 0, 32'h3FC, 0, 1, 0, 0, 0);
    tbl[8]  = mk("bltu_t",  1, 1, 1, 0, BLTU,   32'h3FC, 1, 0, 0, 1, 32'h3FC, 1, 0, 0, 0, 0);
    tbl[9]  = mk("bltu_nt", 1, 1, 1, 0, BLTU,   32'h3FC, 0, 0, 1, 0, 32'h3FC, 0, 0, 0, 0, 0);
    tbl[10] = mk("bgeu_t",  1, 1, 1, 0, BGEU,   32'h3FC, 1, 0, 0, 0, 32'h3FC, 1, 0, 0, 0, 0);
    tbl[11] = mk("bgeu_nt", 1, 1, 1, 0, BGEU,   32'h3FC, 0, 0, 0, 1, 32'h3FC, 0, 0, 0, 0, 0);
    tbl[12] = mk("ill_010", 1, 1, 1, 0, 3'b010, 32'h3FC, 1, 1, 1, 1, 32'h3FC, 0, 0, 1, 0, 0);
    tbl[13] = mk("ill_011", 1, 1, 1, 0, 3'b011, 32'h3FC, 0, 1, 1, 1, 32'h3FC, 0, 0, 1, 0, 0);
    tbl[14] = mk("inv_beq", 1, 0, 1, 0, BEQ,    32'h3FC, 0, 1, 0, 0, 32'h3FC, 0, 0, 0, 0, 0);
    tbl[15] = mk("inv_jmp", 1, 0, 0, 1, BEQ,    32'h3FC, 0, 0, 0, 0, 32'h3FC, 0, 0, 0, 0, 0);
    tbl[16] = mk("jal",     1, 1, 0, 1, BEQ,    32'h3FC, 1, 0, 0, 0, 32'h3FC, 1, 0, 0, 0, 0);
    tbl[17] = mk("br_jmp",  1, 1, 1, 1, BEQ,    32'h3FC, 1, 0, 0, 0, 32'h3FC, 1, 0, 0, 0, 0);
    tbl[18] = mk("inv_ill", 1, 0, 1, 0, 3'b010, 32'h3FC, 0, 1, 1, 1, 32'h3FC, 0, 0, 0, 0, 0);

    reset_n = 1'b0;
    bus.ex_valid = 0; bus.ex_branch = 0; bus.ex_jump = 0; bus.ex_funct3 = 0;
    bus.ex_pc = 0; bus.ex_pred = 0; bus.eq = 0; bus.lt = 0; bus.ltu = 0; bus.f_pc = 0;
    repeat (2) @(posedge clk);

    rst();
    idle("rst_100", 32'h100, 0);
    idle("rst_0fc", 32'h0FC, 0);
    idle("rst_3fc", 32'h3FC, 0);

    for (int i = 0; i < 19; i++) apply(tbl[i]);

    // Basic training at 0x100 (index 0)
    rst();
    idle("t1_pre", 32'h100, 0);
    brq("t1_beq", BEQ, 32'h100, 1, 0, 32'h100, 1, 1, 0);
    idle("t1_post", 32'h100, 1);

    // Saturation at 0x104 (index 1), ex_pred held at 0
    brq("t2_tk1", BNE, 32'h104, 0, 0, 32'h104, 1, 1, 0);
    brq("t2_tk2", BNE, 32'h104, 0, 0, 32'h104, 1, 1, 1);
    brq("t2_tk3", BNE, 32'h104, 0, 0, 32'h104, 1, 1, 1);
    brq("t2_tk4", BNE, 32'h104, 0, 0, 32'h104, 1, 1, 1);
    idle("t2_sat_hi", 32'h104, 1);
    brq("t2_nt1", BNE, 32'h104, 1, 0, 32'h104, 0, 0, 1);
    idle("t2_after_nt1", 32'h104, 1);
    brq("t2_nt2", BNE, 32'h104, 1, 0, 32'h104, 0, 0, 1);
    brq("t2_nt3", BNE, 32'h104, 1, 0, 32'h104, 0, 0, 0);
    brq("t2_nt4", BNE, 32'h104, 1, 0, 32'h104, 0, 0, 0);
    brq("t2_tk5", BNE, 32'h104, 0, 0, 32'h104, 1, 1, 0);
    idle("t2_sat_lo", 32'h104, 0);

    // Aliasing: 0x000 and 0x100 share index 0
    rst();
    brq("t3_a1", BEQ, 32'h000, 1, 0, 32'h100, 1, 1, 0);
    brq("t3_a2", BEQ, 32'h000, 1, 0, 32'h100, 1, 1, 1);
    idle("t3_alias", 32'h100, 1);
    idle("t3_other", 32'h004, 0);

    // Index 0 is now strongly taken; none of these may move it
    apply(mk("t4_jal",  1, 1, 0, 1, BEQ,    32'h0, 0, 0, 0, 0, 32'h0, 1, 0, 0, 1, 1));
    apply(mk("t4_brj1", 1, 1, 1, 1, BEQ,    32'h0, 1, 0, 0, 0, 32'h0, 1, 0, 0, 1, 1));
    apply(mk("t4_brj2", 1, 1, 1, 1, BEQ,    32'h0, 1, 0, 0, 0, 32'h0, 1, 0, 0, 1, 1));
    idle("t4_jmp_keep", 32'h0, 1);
    apply(mk("t4_ill1", 1, 1, 1, 0, 3'b010, 32'h0, 1, 1, 1, 1, 32'h0, 0, 0, 1, 1, 1));
    apply(mk("t4_ill2", 1, 1, 1, 0, 3'b010, 32'h0, 1, 1, 1, 1, 32'h0, 0, 0, 1, 1, 1));
    idle("t4_ill_keep", 32'h0, 1);
    apply(mk("t4_inv1", 1, 0, 1, 0, BEQ,    32'h0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 1, 1));
    apply(mk("t4_inv2", 1, 0, 1, 0, BEQ,    32'h0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 1, 1));
    idle("t4_inv_keep", 32'h0, 1);

    // Same-cycle read/write of index 5, then reset during a training write
    brq("t5_rw", BEQ, 32'h14, 1, 0, 32'h14, 1, 1, 0);
    idle("t5_next", 32'h14, 1);
    apply(mk("t5_rst", 0, 1, 1, 0, BEQ, 32'h14, 0, 1, 0, 0, 32'h14, 1, 1, 0, 0, 0));
    idle("t5_idx5", 32'h14, 0);
    idle("t5_idx0", 32'h00, 0);

`ifdef BPU_STATS_EN
    chk("st_rst_br", stat_branches, 32'd0);
    chk("st_rst_mp", stat_mispredicts, 32'd0);
    for (int i = 0; i < 10; i++)
      brq("st_br", BEQ, 32'h40, 1, (i < 3) ? 1'b0 : 1'b1, 32'h0, 1, (i < 3) ? 1'b1 : 1'b0, 0);
    @(negedge clk);
    chk("st_branches", stat_branches, 32'd10);
    chk("st_mispredicts", stat_mispredicts, 32'd3);
    rst();
    @(negedge clk);
    chk("st_clr_br", stat_branches, 32'd0);
    chk("st_clr_mp", stat_mispredicts, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
